ifetch_warp_sched: RTL
======================

IFETCH_WARP_SCHED -- requirements
Module: ifetch_warp_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, meaning number of hardware warps (power of two, 2..16); WARP_IDX_W = log2(NUM_WARPS).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning PC width.
REQ-003 SHALL have parameter INST_BYTES, default 4, meaning PC step per fetch.
REQ-004 SHALL have parameter LINE_BYTES_LOG, default 6, meaning log2 of cache line bytes.
REQ-005 SHALL have parameter SETS_LOG, default 6, meaning log2 of icache set count.
REQ-006 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority with lowest index first.
REQ-007 SHALL have parameter RESET_PC, default 0, meaning per-warp PC value after reset.
REQ-008 SHALL have port clk, input, 1, meaning the single clock.
REQ-009 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-010 SHALL have port warp_en_bitmap, input, NUM_WARPS, meaning enabled warps.
REQ-011 SHALL have port start_en / start_warp_idx / start_pc, input, 1 / WARP_IDX_W / ADDR_WIDTH, meaning load a warp PC.
REQ-012 SHALL have port ifd_allowin, input, 1, meaning the data stage accepts this cycle.
REQ-013 SHALL have port ifd_cache_miss / ifd_near_miss / ifd_miss_warp_idx, input, 1 / 1 / WARP_IDX_W, meaning miss report for the previous fetch.
REQ-014 SHALL have port wake_bitmap, input, NUM_WARPS, meaning L2 fill done for these warps.
REQ-015 SHALL have port rollback_en / rollback_warp_idx / rollback_pc, input, 1 / WARP_IDX_W / ADDR_WIDTH, meaning redirect from writeback.
REQ-016 SHALL have port fetch_en / fetch_set_idx, output, 1 / SETS_LOG, meaning icache tag read.
REQ-017 SHALL have port out_valid / out_pc / out_warp_idx, output, 1 / ADDR_WIDTH / WARP_IDX_W, meaning the bus to the data stage.
REQ-018 SHALL have port sleep_bitmap, output, NUM_WARPS, meaning warps waiting on an icache fill.

Function
REQ-019 SHALL keep one registered stage valid bit, 0 in reset and 1 from the first clk edge after reset release.
REQ-020 SHALL compute stop[w] = sleep[w] | (miss_hit[w] & (ifd_cache_miss | ifd_near_miss)) | (rollback_en & rollback_warp_idx == w) | (start_en & start_warp_idx == w), with miss_hit[w] meaning ifd_miss_warp_idx == w.
REQ-021 SHALL compute can_fetch = warp_en_bitmap & ~stop.
REQ-022 SHALL drive fetch_en = valid & ifd_allowin & |can_fetch, combinationally in the same cycle.
REQ-023 SHALL make out_valid equal to fetch_en.
REQ-024 SHALL select the granted warp by ARB_MODE; out_warp_idx is the grant and out_pc is that warp's PC.
REQ-025 SHALL drive fetch_set_idx = out_pc[LINE_BYTES_LOG+SETS_LOG-1 : LINE_BYTES_LOG].
REQ-026 SHALL, in RR mode, advance the pointer to grant+1 (mod NUM_WARPS) only when fetch_en is 1 and hold it otherwise.
REQ-027 SHALL, in RR mode, grant the first requester at or after the pointer, wrapping around; the pointer resets to 0.
REQ-028 SHALL give each per-warp PC the next-value priority: rollback -> rollback_pc; else miss or near-miss -> PC - INST_BYTES; else start -> start_pc; else granted with fetch_en -> PC + INST_BYTES; else hold.
REQ-029 SHALL make PC arithmetic modulo 2^ADDR_WIDTH, so wrap-around at 0 and at the maximum value is silent.
REQ-030 SHALL update sleep_nxt = (sleep | (onehot(ifd_miss_warp_idx) & ifd_cache_miss)) & ~wake_bitmap, so wake wins over a same-cycle miss; near_miss never sets sleep.
REQ-031 SHALL make sleep_bitmap the registered sleep state.
REQ-032 SHALL keep a disabled warp's PC and sleep bit unaffected by warp_en_bitmap; only fetch eligibility changes.
REQ-033 SHALL drive out_pc and out_warp_idx from the current grant whenever fetch_en is 0; they are don't-care.
REQ-034 SHALL produce no X on outputs when can_fetch is 0.

Reset
REQ-035 SHALL, on rst_n low, asynchronously force valid=0, every PC=RESET_PC, sleep_bitmap=0 and RR pointer=0, which gives fetch_en=0 and out_valid=0.
REQ-036 SHALL discard all in-flight state when reset is asserted mid-operation, with no partial PC update.

Verification
REQ-037 SHALL check: 4 warps enabled, allowin=1, RR mode -> grants 0,1,2,3,0 on consecutive cycles with PCs 0,0,0,0,4.
REQ-038 SHALL check: cache_miss for warp 2 at PC 0x8 -> warp 2 PC becomes 0x4, sleep_bitmap=0100, it is skipped until wake_bitmap=0100, then it refetches 0x4.
REQ-039 SHALL check: rollback warp 1 to 0x100 in the same cycle as a miss for warp 1 -> PC=0x100.
REQ-040 SHALL check: ifd_allowin=0 for 3 cycles -> fetch_en=0 and PCs and pointer unchanged.
REQ-041 SHALL check: ARB_MODE=1 with warps 1 and 3 requesting -> warp 1 granted every cycle.
REQ-042 SHALL check: PC=0xFFFFFFFC granted -> next PC 0x0; rst_n pulsed low mid-run -> all PCs=RESET_PC and fetch_en=0 immediately.

Source files
------------

// File: rtl/ifetch_warp_sched.sv
// Instruction fetch warp scheduler: picks one ready warp per cycle,
// owns the per-warp PCs and tracks warps sleeping on an icache fill.
module ifetch_warp_sched #(
    parameter int unsigned NUM_WARPS      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned INST_BYTES     = 4,
    parameter int unsigned LINE_BYTES_LOG = 6,
    parameter int unsigned SETS_LOG       = 6,
    parameter int unsigned ARB_MODE       = 0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    localparam int unsigned WARP_IDX_W    = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_WARPS-1:0]  warp_en_bitmap,
    input  logic                  start_en,
    input  logic [WARP_IDX_W-1:0] start_warp_idx,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  ifd_allowin,
    input  logic                  ifd_cache_miss,
    input  logic                  ifd_near_miss,
    input  logic [WARP_IDX_W-1:0] ifd_miss_warp_idx,
    input  logic [NUM_WARPS-1:0]  wake_bitmap,
    input  logic                  rollback_en,
    input  logic [WARP_IDX_W-1:0] rollback_warp_idx,
    input  logic [ADDR_WIDTH-1:0] rollback_pc,
    output logic                  fetch_en,
    output logic [SETS_LOG-1:0]   fetch_set_idx,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [WARP_IDX_W-1:0] out_warp_idx,
    output logic [NUM_WARPS-1:0]  sleep_bitmap
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_BYTES);

    logic                  valid_q, valid_d;
    logic [WARP_IDX_W-1:0] ptr_q, ptr_d;
    logic [NUM_WARPS-1:0]  sleep_q, sleep_d;
    logic [ADDR_WIDTH-1:0] pc_q [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] pc_d [NUM_WARPS];

    logic [NUM_WARPS-1:0]  miss_hit, rb_hit, start_hit;
    logic [NUM_WARPS-1:0]  stop, can_fetch;
    logic [WARP_IDX_W-1:0] grant, idx;
    logic                  any_miss;

    always_comb begin
        any_miss = ifd_cache_miss | ifd_near_miss;
        for (int w = 0; w < NUM_WARPS; w++) begin
            miss_hit[w]  = ifd_miss_warp_idx == WARP_IDX_W'(w);
            rb_hit[w]    = rollback_en & (rollback_warp_idx == WARP_IDX_W'(w));
            start_hit[w] = start_en & (start_warp_idx == WARP_IDX_W'(w));
        end
        stop      = sleep_q | (miss_hit & {NUM_WARPS{any_miss}}) | rb_hit | start_hit;
        can_fetch = warp_en_bitmap & ~stop;
        fetch_en  = valid_q & ifd_allowin & (|can_fetch);
    end

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        grant = (ARB_MODE == 1) ? '0 : ptr_q;
        idx   = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = (ARB_MODE == 1) ? WARP_IDX_W'(i) : ptr_q + WARP_IDX_W'(i);
            if (can_fetch[idx]) grant = idx;
        end
    end

    assign out_valid     = fetch_en;
    assign out_warp_idx  = grant;
    assign out_pc        = pc_q[grant];
    assign fetch_set_idx = out_pc[LINE_BYTES_LOG+SETS_LOG-1:LINE_BYTES_LOG];
    assign sleep_bitmap  = sleep_q;

    always_comb begin
        valid_d = 1'b1;
        ptr_d   = ptr_q;
        if (fetch_en && ARB_MODE == 0) ptr_d = grant + WARP_IDX_W'(1);
        sleep_d = (sleep_q | (miss_hit & {NUM_WARPS{ifd_cache_miss}})) & ~wake_bitmap;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w] = pc_q[w];
            if (rb_hit[w])
                pc_d[w] = rollback_pc;
            else if (miss_hit[w] && any_miss)
                pc_d[w] = pc_q[w] - STEP;
            else if (start_hit[w])
                pc_d[w] = start_pc;
            else if (fetch_en && grant == WARP_IDX_W'(w))
                pc_d[w] = pc_q[w] + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
            sleep_q <= '0;
            for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            sleep_q <= sleep_d;
            for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= pc_d[w];
        end
    end

endmodule
